// File: rtl/psum_ofifo_pkg.sv
// Shared constants for the partial-sum output FIFO.
// Default lane count, psum width and depth live here.
// The pointer width is derived from the depth so that every file agrees on it.
package psum_ofifo_pkg;

   localparam int COL_DEFAULT     = 8;
   localparam int PSUM_BW_DEFAULT = 32;
   localparam int DEPTH_DEFAULT   = 64;
   localparam int PTR_W_DEFAULT   = $clog2(DEPTH_DEFAULT);

   // Pointer width for an arbitrary power-of-two depth.
   function automatic int ptr_width(input int d);
      return $clog2(d);
   endfunction

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane FIFO for one column of partial sums.
// The head entry is presented combinationally on dout.
// A push into a full lane is still accepted when a pop frees a slot at the same edge.
// Otherwise the push is dropped and signalled on drop for that cycle.
// Storage is deliberately not reset; only the pointers and the count are.
module ofifo_lane
   import psum_ofifo_pkg::*;
#(
   parameter  int psum_bw = PSUM_BW_DEFAULT,
   parameter  int depth   = DEPTH_DEFAULT,
   localparam int ptr_w   = ptr_width(depth)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [psum_bw-1:0] din,
   output logic [psum_bw-1:0] dout,
   output logic [ptr_w:0]     count,
   output logic               empty,
   output logic               full,
   output logic               drop
);

   logic [psum_bw-1:0] mem [depth];
   logic [ptr_w-1:0]   wptr;
   logic [ptr_w-1:0]   rptr;
   logic               push_ok;
   logic               pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (ptr_w+1)'(depth));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign drop    = push && !push_ok;
   assign dout    = mem[rptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + ptr_w'(1);
         if (pop_ok)  rptr <= rptr + ptr_w'(1);
         count <= count + (ptr_w+1)'(push_ok) - (ptr_w+1)'(pop_ok);
      end
   end

   // Entry storage, written only on an accepted push outside reset.
   always_ff @(posedge clk) begin
      if (reset && push_ok) mem[wptr] <= din;
   end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO that collects skewed south-edge partial sums from a systolic array.
// Each column has its own ofifo_lane.
// A row pops only once every lane has data.
// The popped row is registered on out with a one-cycle out_valid pulse.
// Optional feature: define PSUM_OFIFO_RELU_EN to clamp negative lanes of the popped row to zero.
module psum_ofifo
   import psum_ofifo_pkg::*;
#(
   parameter int col     = COL_DEFAULT,
   parameter int psum_bw = PSUM_BW_DEFAULT,
   parameter int depth   = DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   out_valid,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   overflow
);

   localparam int ptr_w = ptr_width(depth);

   logic [col-1:0][psum_bw-1:0] lane_head;
   logic [col-1:0][psum_bw-1:0] popped_row;
   logic [col-1:0][ptr_w:0]     lane_count;
   logic [col-1:0]              lane_empty;
   logic [col-1:0]              lane_full;
   logic [col-1:0]              lane_drop;
   logic                        pop_accept;
   logic                        unused_counts;

   for (genvar i = 0; i < col; i++) begin : g_lane
      ofifo_lane #(
         .psum_bw (psum_bw),
         .depth   (depth)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .push  (wr[i]),
         .pop   (pop_accept),
         .din   (in[psum_bw*i +: psum_bw]),
         .dout  (lane_head[i]),
         .count (lane_count[i]),
         .empty (lane_empty[i]),
         .full  (lane_full[i]),
         .drop  (lane_drop[i])
      );
   end

   // Flags come only from registered lane state, never from this cycle's strobes.
   assign o_valid       = ~|lane_empty;
   assign o_full        = |lane_full;
   assign o_ready       = ~o_full;
   assign pop_accept    = rd && o_valid;
   assign unused_counts = ^lane_count;

   // Shape the popped heads before they are registered; ReLU only touches this path.
   always_comb begin
      popped_row = lane_head;
`ifdef PSUM_OFIFO_RELU_EN
      for (int i = 0; i < col; i++) begin
         if (lane_head[i][psum_bw-1]) popped_row[i] = '0;
      end
`else
      popped_row = lane_head;
`endif
   end

   // Output row register, pop pulse and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out       <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         out_valid <= pop_accept;
         if (pop_accept) out <= popped_row;
         if (|lane_drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed self-checking bench for psum_ofifo with its default parameters.
// Expected rows are hand-built; the ReLU expectation follows PSUM_OFIFO_RELU_EN.
module tb_psum_ofifo;

   localparam int COL = 8;
   localparam int BW  = 32;
   localparam int W   = COL * BW;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] in;
   logic [7:0]   wr;
   logic         rd;
   logic [W-1:0] out;
   logic         out_valid;
   logic         o_valid;
   logic         o_full;
   logic         o_ready;
   logic         overflow;

   int n_assert = 0;
   int n_fail   = 0;

   psum_ofifo #(.col(COL), .psum_bw(BW), .depth(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .wr        (wr),
      .rd        (rd),
      .out       (out),
      .out_valid (out_valid),
      .o_valid   (o_valid),
      .o_full    (o_full),
      .o_ready   (o_ready),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Row whose lane i holds base+i.
   function automatic logic [W-1:0] row_of(input logic [31:0] base);
      logic [W-1:0] r;
      for (int i = 0; i < COL; i++) r[BW*i +: BW] = base + 32'(i);
      return r;
   endfunction

   // Row with a single lane populated.
   function automatic logic [W-1:0] lane_row(input int lane, input logic [31:0] val);
      logic [W-1:0] r;
      r = '0;
      r[BW*lane +: BW] = val;
      return r;
   endfunction

   // Expected effect of the optional output clamp.
   function automatic logic [W-1:0] relu_row(input logic [W-1:0] r);
      logic [W-1:0] q;
      q = r;
`ifdef PSUM_OFIFO_RELU_EN
      for (int i = 0; i < COL; i++) if (r[BW*i+BW-1]) q[BW*i +: BW] = '0;
`endif
      return q;
   endfunction

   task automatic applyStimulus(input logic rst_n, input logic [7:0] w,
                                input logic [W-1:0] d, input logic r);
      reset = rst_n;
      wr    = w;
      in    = d;
      rd    = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [W-1:0] exp_row;
      logic [W-1:0] neg_row;

      $display("[TB] reset with concurrent wr/rd");
      applyStimulus(1'b0, 8'hFF, row_of(32'd9), 1'b1);
      applyStimulus(1'b0, 8'hFF, row_of(32'd9), 1'b1);
      checkOutput("rst_o_valid", o_valid, 0);
      checkOutput("rst_o_full", o_full, 0);
      checkOutput("rst_o_ready", o_ready, 1);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out", out, 0);

      $display("[TB] skewed fill");
      for (int i = 0; i < COL; i++) begin
         applyStimulus(1'b1, 8'(1 << i), lane_row(i, 32'(100 + i)), 1'b0);
         checkOutput($sformatf("skew_o_valid_%0d", i), o_valid, (i == COL-1) ? 1 : 0);
      end
      applyStimulus(1'b1, 8'h00, '0, 1'b1);
      checkOutput("skew_out", out, row_of(32'd100));
      checkOutput("skew_out_valid", out_valid, 1);
      applyStimulus(1'b1, 8'h00, '0, 1'b0);
      checkOutput("skew_pulse_end", out_valid, 0);
      checkOutput("skew_out_hold", out, row_of(32'd100));
      checkOutput("skew_empty", o_valid, 0);

      $display("[TB] rd while lane 3 empty");
      applyStimulus(1'b1, 8'hF7, row_of(32'd200), 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 8'h00, '0, 1'b1);
         checkOutput("l3_no_pulse", out_valid, 0);
         checkOutput("l3_out_hold", out, row_of(32'd100));
      end
      applyStimulus(1'b1, 8'h08, row_of(32'd200), 1'b0);
      checkOutput("l3_o_valid", o_valid, 1);
      applyStimulus(1'b1, 8'h00, '0, 1'b1);
      checkOutput("l3_out", out, row_of(32'd200));

      $display("[TB] simultaneous push and pop");
      applyStimulus(1'b1, 8'hFF, row_of(32'd300), 1'b0);
      applyStimulus(1'b1, 8'hFF, row_of(32'd400), 1'b1);
      checkOutput("pp_out", out, row_of(32'd300));
      checkOutput("pp_out_valid", out_valid, 1);
      checkOutput("pp_o_valid", o_valid, 1);
      applyStimulus(1'b1, 8'h00, '0, 1'b1);
      checkOutput("pp_out2", out, row_of(32'd400));
      checkOutput("pp_drained", o_valid, 0);

      $display("[TB] negative lanes");
      for (int i = 0; i < COL; i++)
         neg_row[BW*i +: BW] = (i % 2 == 0) ? 32'hFFFF_FFF6 : 32'(5 + i);
      applyStimulus(1'b1, 8'hFF, neg_row, 1'b0);
      applyStimulus(1'b1, 8'h00, '0, 1'b1);
      checkOutput("neg_out", out, relu_row(neg_row));

      $display("[TB] lane 0 overflow");
      for (int k = 0; k < 64; k++) begin
         applyStimulus(1'b1, 8'h01, lane_row(0, 32'(1000 + k)), 1'b0);
         if (k == 62) checkOutput("ovf_not_full_63", o_full, 0);
      end
      checkOutput("ovf_o_full", o_full, 1);
      checkOutput("ovf_o_ready", o_ready, 0);
      checkOutput("ovf_clear_yet", overflow, 0);
      applyStimulus(1'b1, 8'h01, lane_row(0, 32'hDEAD), 1'b0);
      checkOutput("ovf_set", overflow, 1);
      checkOutput("ovf_still_full", o_full, 1);
      applyStimulus(1'b1, 8'hFE, row_of(32'd2000), 1'b0);
      checkOutput("ovf_o_valid", o_valid, 1);
      applyStimulus(1'b1, 8'h01, lane_row(0, 32'h5555), 1'b1);
      exp_row = row_of(32'd2000);
      exp_row[31:0] = 32'd1000;
      checkOutput("full_pushpop_out", out, exp_row);
      checkOutput("full_pushpop_full", o_full, 1);
      for (int k = 0; k < 64; k++) begin
         applyStimulus(1'b1, 8'hFE, row_of(32'(3000 + 8*k)), 1'b0);
         applyStimulus(1'b1, 8'h00, '0, 1'b1);
         checkOutput($sformatf("drain_lane0_%0d", k), out[31:0],
                     (k < 63) ? 32'(1001 + k) : 32'h5555);
      end
      checkOutput("drain_o_valid", o_valid, 0);
      checkOutput("drain_o_full", o_full, 0);
      checkOutput("ovf_sticky", overflow, 1);

      $display("[TB] reset mid-operation and wrap stream");
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'hFF, row_of(32'(500 + 8*k)), 1'b0);
      checkOutput("pre_rst_o_valid", o_valid, 1);
      applyStimulus(1'b0, 8'hFF, row_of(32'd900), 1'b1);
      checkOutput("mid_rst_o_valid", o_valid, 0);
      checkOutput("mid_rst_overflow", overflow, 0);
      checkOutput("mid_rst_out", out, 0);
      checkOutput("mid_rst_out_valid", out_valid, 0);
      checkOutput("mid_rst_o_ready", o_ready, 1);
      applyStimulus(1'b1, 8'hFF, row_of(32'h1000_0000), 1'b0);
      for (int k = 1; k < 128; k++) begin
         applyStimulus(1'b1, 8'hFF, row_of(32'h1000_0000 + 32'(k * 256)), 1'b1);
         checkOutput($sformatf("wrap_row_%0d", k-1), out,
                     row_of(32'h1000_0000 + 32'((k-1) * 256)));
      end
      applyStimulus(1'b1, 8'h00, '0, 1'b1);
      checkOutput("wrap_row_127", out, row_of(32'h1000_0000 + 32'(127 * 256)));
      checkOutput("wrap_last_pulse", out_valid, 1);
      applyStimulus(1'b1, 8'h00, '0, 1'b0);
      checkOutput("wrap_idle_pulse", out_valid, 0);
      checkOutput("wrap_empty", o_valid, 0);
      checkOutput("wrap_no_ovf", overflow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_ofifo.md
PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 Parameter col, default 8: number of array columns (lanes) collected.
REQ-002 Parameter psum_bw, default 32: partial-sum width per lane, two's complement.
REQ-003 Parameter depth, default 64: entries per lane, power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-006 in  input  psum_bw*col  south-edge psums; lane i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 wr  input  col  per-lane write strobe, driven by the array's per-column valid bits.
REQ-008 rd  input  1  row pop request.
REQ-009 out  output  psum_bw*col  registered popped row, using the same lane packing as in.
REQ-010 out_valid  output  1  one-cycle pulse marking that out holds a newly popped row.
REQ-011 o_valid  output  1  high when every lane holds at least one entry.
REQ-012 o_full  output  1  high when any lane holds depth entries.
REQ-013 o_ready  output  1  equals ~o_full.
REQ-014 overflow  output  1  sticky flag: a write was dropped.

Function
REQ-015 Each lane SHALL be an independent FIFO; wr[i]==1 pushes lane i of in into lane i at that edge.
REQ-016 Writes arrive skewed across lanes, one lane per cycle as the diagonal wavefront exits the array; no lane ordering SHALL be assumed.
REQ-017 A write to a full lane SHALL be dropped, leave that lane unchanged, and set overflow.
REQ-018 A pop is accepted when rd==1 and o_valid==1 at the edge; it removes the head entry of every lane simultaneously.
REQ-019 rd==1 while o_valid==0 SHALL be ignored: no state change and no out_valid pulse.
REQ-020 Pop latency is one cycle: the edge after an accepted pop, out holds the popped heads and out_valid==1 for exactly one cycle.
REQ-021 out SHALL hold its value until the next accepted pop.
REQ-022 A simultaneous push and pop on the same lane SHALL be accepted in the same cycle and leave that lane's count unchanged.
REQ-023 A push to a full lane in the same cycle as an accepted pop SHALL succeed; fullness is evaluated before the edge, with the pop freeing the slot.
REQ-024 Per-lane read and write pointers are log2(depth) bits wide and wrap modulo depth.
REQ-025 Per-lane counts are log2(depth)+1 bits wide.
REQ-026 o_valid, o_full and o_ready SHALL be combinational from the registered counts, not from current-cycle inputs.
REQ-027 overflow SHALL clear only on reset.

Reset
REQ-028 reset==0 SHALL clear all pointers, counts, overflow, out (to 0) and out_valid (to 0).
REQ-029 The reset state gives o_valid=0, o_full=0 and o_ready=1.
REQ-030 Reset SHALL take priority over a concurrent wr or rd.
REQ-031 Reset mid-operation discards all stored entries.
REQ-032 Storage contents are not cleared by reset.

Configuration
REQ-033 Macro PSUM_OFIFO_RELU_EN, when defined, SHALL clamp each lane of the popped row to 0 if negative before registering it into out.
REQ-034 Without PSUM_OFIFO_RELU_EN, out SHALL carry the stored values unmodified.
REQ-035 PSUM_OFIFO_RELU_EN SHALL NOT affect storage, counts or flags.

Structure
REQ-036 A shared package psum_ofifo_pkg SHALL hold the default col, psum_bw and depth constants.
REQ-037 psum_ofifo_pkg SHALL also hold a clog2-derived pointer-width constant.
REQ-038 One sub-module, ofifo_lane, SHALL implement a single-lane FIFO with push, pop, data, count, empty and full.
REQ-039 psum_ofifo SHALL instantiate col copies of ofifo_lane in a generate loop and add the cross-lane flags, the output register and the optional ReLU.

Verification
REQ-040 Skewed fill: for cycles 0..7 assert wr[i] at cycle i with lane value 100+i -> o_valid rises the cycle after lane 7's write; rd -> out lanes 100..107 and a single out_valid pulse.
REQ-041 Fill lane 0 with 64 writes, then one more write with value 0xDEAD -> o_full=1, o_ready=0, overflow=1, and the dropped value never appears on out.
REQ-042 With all lanes holding 1 entry, assert rd and wr=8'hFF in the same cycle -> pop accepted, counts stay 1, next pop returns the new data.
REQ-043 rd held high with lane 3 empty -> no out_valid pulse and out unchanged.
REQ-044 Write 0xFFFFFFF6 (-10) to all lanes and pop -> out lanes 0 with PSUM_OFIFO_RELU_EN defined, 0xFFFFFFF6 without it.
REQ-045 Fill 5 rows, pulse reset low for one cycle -> o_valid=0, overflow=0, out=0; a following 128-row push/pop stream checks pointer wrap with all data in order.
